// File: rtl/edge_counter_bank_pkg.sv
// ----------------------------------------------------------------------------
// edge_counter_pkg
//   Shared constants and helpers for the edge counter bank.
//   - EDGE_* : 2-bit edge selection codes driven on edge_mode
//   - calc_bytes : number of OUT_W-wide slices needed to read a CNT_W counter
//   - sel_width  : width of a select field for n choices (at least one bit)
//   Build option: COUNTER_SATURATE_EN (see edge_counter_bank).
// ----------------------------------------------------------------------------
package edge_counter_pkg;

    localparam logic [1:0] EDGE_BOTH = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    // Number of readout slices, rounded up so the top bits are never lost.
    function automatic int calc_bytes(input int cnt_w, input int out_w);
        return (cnt_w + out_w - 1) / out_w;
    endfunction

    // Select width for n choices; a single choice still gets a 1-bit port.
    function automatic int sel_width(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_counter_bank_sync_detect.sv
// ----------------------------------------------------------------------------
// edge_sync_detect
//   Synchronises one asynchronous input through SYNC_STAGES flops, keeps the
//   previous synchronised value, and decodes edge_mode into a one-cycle
//   edge pulse. The synchroniser and prev flop run unconditionally so that
//   an edge seen while the counter is paused or cleared is consumed then and
//   never shows up later.
// Ports
//   clk25      in  clock, all state on posedge
//   rst        in  asynchronous active-high reset
//   sig_in     in  asynchronous event input
//   edge_mode  in  00 both, 01 rising, 10 falling, 11 none
//   edge_pulse out high for one cycle when a selected edge is detected
// ----------------------------------------------------------------------------
module edge_sync_detect
    import edge_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       sig_in,
    input  logic [1:0] edge_mode,
    output logic       edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   sync_out_s;
    logic                   pulse_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain and previous-value flop.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            prev_r <= sync_out_s;
        end
    end

    // Edge decode; mode is applied combinationally so a mode change only
    // affects the next edge and never manufactures one.
    always_comb begin
        pulse_s = 1'b0;
        case (edge_mode)
            EDGE_BOTH: pulse_s = sync_out_s ^ prev_r;
            EDGE_RISE: pulse_s = sync_out_s & ~prev_r;
            EDGE_FALL: pulse_s = ~sync_out_s & prev_r;
            EDGE_NONE: pulse_s = 1'b0;
            default:   pulse_s = 1'b0;
        endcase
    end

    assign edge_pulse = pulse_s;

endmodule

// File: rtl/edge_counter_bank.sv
// ----------------------------------------------------------------------------
// edge_counter_bank
//   Multi-channel edge counter. Each channel synchronises an async input,
//   detects the selected edges and counts them. Snapshot registers give a
//   coherent copy of all counters, read out one OUT_W slice at a time
//   through a registered mux.
// Parameters
//   NUM_CH (1..8), CNT_W (1..32), SYNC_STAGES (>=2), OUT_W
// Ports
//   clk25     in   single clock
//   rst       in   asynchronous active-high reset
//   sig_in    in   [NUM_CH]   async event inputs
//   clr       in   sync clear of counters and ovf (snapshots untouched)
//   pause     in   inhibit counting; edges during pause are dropped
//   edge_mode in   [2]        00 both, 01 rising, 10 falling, 11 none
//   snap      in   copy live counters into snapshots (tie high for live view)
//   ch_sel    in   channel to read
//   byte_sel  in   slice to read, 0 = LSBs
//   dout      out  [OUT_W]    registered readout, 0 for out-of-range selects
//   ovf       out  [NUM_CH]   sticky per-channel overflow
// Build option
//   COUNTER_SATURATE_EN : counters hold at all-ones instead of wrapping;
//                         ovf is set by the first blocked edge.
// ----------------------------------------------------------------------------
module edge_counter_bank
    import edge_counter_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = 14,
    parameter  int SYNC_STAGES = 2,
    parameter  int OUT_W       = 8,
    localparam int BYTES       = calc_bytes(CNT_W, OUT_W),
    localparam int CH_SEL_W    = sel_width(NUM_CH),
    localparam int BYTE_SEL_W  = sel_width(BYTES)
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     sig_in,
    input  logic                  clr,
    input  logic                  pause,
    input  logic [1:0]            edge_mode,
    input  logic                  snap,
    input  logic [CH_SEL_W-1:0]   ch_sel,
    input  logic [BYTE_SEL_W-1:0] byte_sel,
    output logic [OUT_W-1:0]      dout,
    output logic [NUM_CH-1:0]     ovf
);

    localparam int               PAD_W   = BYTES * OUT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] pulse_s;
    logic [CNT_W-1:0]  cnt_r  [NUM_CH];
    logic [CNT_W-1:0]  snap_r [NUM_CH];
    logic [NUM_CH-1:0] ovf_r;
    logic [OUT_W-1:0]  dout_r;
    logic [PAD_W-1:0]  pad_s;
    logic [OUT_W-1:0]  rd_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_sync_detect #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_detect (
            .clk25      (clk25),
            .rst        (rst),
            .sig_in     (sig_in[g]),
            .edge_mode  (edge_mode),
            .edge_pulse (pulse_s[g])
        );
    end

    // Live counters and sticky overflow: clr beats pause beats counting.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_r[c] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr) begin
                    cnt_r[c] <= '0;
                    ovf_r[c] <= 1'b0;
                end else if (pause) begin
                    cnt_r[c] <= cnt_r[c];
                    ovf_r[c] <= ovf_r[c];
                end else if (pulse_s[c]) begin
                    if (cnt_r[c] == CNT_MAX) begin
`ifdef COUNTER_SATURATE_EN
                        cnt_r[c] <= CNT_MAX;
`else
                        cnt_r[c] <= '0;
`endif
                        ovf_r[c] <= 1'b1;
                    end else begin
                        cnt_r[c] <= cnt_r[c] + CNT_W'(1);
                        ovf_r[c] <= ovf_r[c];
                    end
                end else begin
                    cnt_r[c] <= cnt_r[c];
                    ovf_r[c] <= ovf_r[c];
                end
            end
        end
    end

    // Snapshots capture the counter Q, i.e. the value before this edge's
    // count or clear, so a clr+snap pair preserves the final count.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                snap_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (snap) begin
                    snap_r[c] <= cnt_r[c];
                end else begin
                    snap_r[c] <= snap_r[c];
                end
            end
        end
    end

    // Readout mux built from select masks: an out-of-range channel or slice
    // matches nothing and naturally yields zero. The snapshot is first
    // zero-extended to a whole number of slices.
    always_comb begin
        pad_s = '0;
        rd_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pad_s[CNT_W-1:0] = pad_s[CNT_W-1:0]
                             | (snap_r[c] & {CNT_W{ch_sel == CH_SEL_W'(c)}});
        end
        for (int b = 0; b < BYTES; b++) begin
            rd_s = rd_s
                 | (pad_s[b*OUT_W +: OUT_W] & {OUT_W{byte_sel == BYTE_SEL_W'(b)}});
        end
    end

    // Registered readout.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            dout_r <= '0;
        end else begin
            dout_r <= rd_s;
        end
    end

    assign dout = dout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_edge_counter_bank.sv
// ----------------------------------------------------------------------------
// Testbench for edge_counter_bank (default parameters: 2 channels, 14 bits).
// Directed sequences for reset, edge modes, pause, wrap/saturate, coherent
// snapshot readout and clr+snap, followed by randomized stimulus checked
// against a history-based reference model.
// ----------------------------------------------------------------------------
module tb_edge_counter_bank;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 14;
    localparam int SYNC_STAGES = 2;
    localparam int OUT_W       = 8;
    localparam int BYTES       = 2;
    localparam int CH_SEL_W    = 1;
    localparam int BYTE_SEL_W  = 1;
    localparam longint CNT_MOD = longint'(1) << CNT_W;

    localparam logic [1:0] M_BOTH = 2'b00;
    localparam logic [1:0] M_RISE = 2'b01;
    localparam logic [1:0] M_FALL = 2'b10;
    localparam logic [1:0] M_NONE = 2'b11;

    logic                  clk25 = 1'b0;
    logic                  rst;
    logic [NUM_CH-1:0]     sig_in;
    logic                  clr;
    logic                  pause;
    logic [1:0]            edge_mode;
    logic                  snap;
    logic [CH_SEL_W-1:0]   ch_sel;
    logic [BYTE_SEL_W-1:0] byte_sel;
    logic [OUT_W-1:0]      dout;
    logic [NUM_CH-1:0]     ovf;

    int n_checks = 0;
    int n_fail   = 0;

    edge_counter_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .OUT_W       (OUT_W)
    ) dut (
        .clk25     (clk25),
        .rst       (rst),
        .sig_in    (sig_in),
        .clr       (clr),
        .pause     (pause),
        .edge_mode (edge_mode),
        .snap      (snap),
        .ch_sel    (ch_sel),
        .byte_sel  (byte_sel),
        .dout      (dout),
        .ovf       (ovf)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk25);
            #1;
        end
    endtask

    task automatic toggle(input int ch, input int n);
        repeat (n) begin
            sig_in[ch] = ~sig_in[ch];
            cyc(1);
        end
    endtask

    task automatic settle();
        cyc(SYNC_STAGES + 3);
    endtask

    task automatic clear();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic read(input int ch, input int b, output logic [OUT_W-1:0] v);
        ch_sel   = CH_SEL_W'(ch);
        byte_sel = BYTE_SEL_W'(b);
        cyc(2);
        v = dout;
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         toggles;
        int         exp;
    } mode_vec_t;

    // Reference model state
    longint            m_cnt  [NUM_CH];
    longint            m_snap [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;
    logic [NUM_CH-1:0] m_hist [$];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c]  = 0;
            m_snap[c] = 0;
        end
        m_ovf = '0;
        m_hist.delete();
        repeat (SYNC_STAGES + 2) m_hist.push_back('0);
    endtask

    // One clock edge of the model; returns the dout value the edge loads.
    task automatic model_step(output longint exp_dout);
        logic nv, ov, hit;
        if (int'(ch_sel) < NUM_CH && int'(byte_sel) < BYTES)
            exp_dout = (m_snap[ch_sel] >> (OUT_W * int'(byte_sel))) & 255;
        else
            exp_dout = 0;
        // A sample taken at edge k is counted at edge k+SYNC_STAGES.
        m_hist.push_front(sig_in);
        void'(m_hist.pop_back());
        if (snap)
            for (int c = 0; c < NUM_CH; c++) m_snap[c] = m_cnt[c];
        for (int c = 0; c < NUM_CH; c++) begin
            nv = m_hist[SYNC_STAGES][c];
            ov = m_hist[SYNC_STAGES + 1][c];
            case (edge_mode)
                M_BOTH:  hit = (nv != ov);
                M_RISE:  hit = nv && !ov;
                M_FALL:  hit = !nv && ov;
                default: hit = 1'b0;
            endcase
            if (clr) begin
                m_cnt[c] = 0;
                m_ovf[c] = 1'b0;
            end else if (!pause && hit) begin
`ifdef COUNTER_SATURATE_EN
                if (m_cnt[c] == CNT_MOD - 1) m_ovf[c] = 1'b1;
                else m_cnt[c] = m_cnt[c] + 1;
`else
                m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
                if (m_cnt[c] == 0) m_ovf[c] = 1'b1;
`endif
            end
        end
    endtask

    initial begin
        mode_vec_t         vt [4];
        logic [OUT_W-1:0]  v;
        longint            exp_dout;
        longint            exp_lo, exp_hi;

        rst = 1'b1; sig_in = '0; clr = 1'b0; pause = 1'b0;
        edge_mode = M_BOTH; snap = 1'b1; ch_sel = '0; byte_sel = '0;
        cyc(2);
        check("reset_dout", dout, 0);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;

        // 1: asynchronous reset mid-count
        toggle(0, 37);
        settle();
        read(0, 0, v);
        check("precount_37", v, 37);
        @(negedge clk25);
        rst = 1'b1;
        sig_in = '0;
        #1;
        check("async_rst_dout", dout, 0);
        check("async_rst_ovf", ovf, 0);
        cyc(1);
        rst = 1'b0;
        toggle(0, 3);
        settle();
        read(0, 0, v);
        check("restart_count", v, 3);

        // 2: edge modes, five toggles from idle-low
        vt[0] = '{"mode_both", M_BOTH, 5, 5};
        vt[1] = '{"mode_rise", M_RISE, 5, 3};
        vt[2] = '{"mode_fall", M_FALL, 5, 2};
        vt[3] = '{"mode_none", M_NONE, 5, 0};
        for (int i = 0; i < 4; i++) begin
            sig_in[0] = 1'b0;
            settle();
            clear();
            edge_mode = vt[i].mode;
            toggle(0, vt[i].toggles);
            settle();
            read(0, 0, v);
            check(vt[i].name, v, vt[i].exp);
            read(0, 1, v);
            check({vt[i].name, "_hi"}, v, 0);
        end

        // 4: edges during pause are dropped, not deferred
        edge_mode = M_BOTH;
        sig_in[0] = 1'b0;
        settle();
        clear();
        toggle(0, 2);
        settle();
        pause = 1'b1;
        toggle(0, 4);
        settle();
        pause = 1'b0;
        settle();
        read(0, 0, v);
        check("pause_drop", v, 2);

        // 5: coherent snapshot of ch1 at 0x1234 while counting continues
        clear();
        toggle(1, 16'h1234);
        settle();
        snap = 1'b0;
        cyc(1);
        snap = 1'b1;
        cyc(1);
        snap = 1'b0;
        toggle(1, 10);
        settle();
        read(1, 0, v);
        check("snap_held_lo", v, 8'h34);
        read(1, 1, v);
        check("snap_held_hi", v, 8'h12);
        snap = 1'b1;
        settle();
        read(1, 0, v);
        check("snap_live_lo", v, (16'h1234 + 10) & 255);
        check("ch1_no_ovf", ovf[1], 0);

        // 3: counter boundary on ch0
        ch_sel = '0;
        sig_in[0] = 1'b0;
        settle();
        clear();
        toggle(0, 16383);
        settle();
        read(0, 0, v);
        check("max_lo", v, 8'hFF);
        read(0, 1, v);
        check("max_hi", v, 8'h3F);
        check("max_no_ovf", ovf[0], 0);
        toggle(0, 1);
        settle();
`ifdef COUNTER_SATURATE_EN
        exp_lo = 255; exp_hi = 63;
`else
        exp_lo = 0; exp_hi = 0;
`endif
        read(0, 0, v);
        check("past_max_lo", v, exp_lo);
        read(0, 1, v);
        check("past_max_hi", v, exp_hi);
        check("past_max_ovf", ovf[0], 1);

        // 6: clr and snap together keep the pre-clear value in the snapshot
        toggle(0, 9);
        settle();
        check("ovf_sticky", ovf[0], 1);
`ifdef COUNTER_SATURATE_EN
        exp_lo = 255; exp_hi = 63;
`else
        exp_lo = 9; exp_hi = 0;
`endif
        snap = 1'b0;
        cyc(1);
        clr = 1'b1;
        snap = 1'b1;
        cyc(1);
        clr = 1'b0;
        snap = 1'b0;
        settle();
        read(0, 0, v);
        check("clrsnap_lo", v, exp_lo);
        read(0, 1, v);
        check("clrsnap_hi", v, exp_hi);
        check("clrsnap_ovf", ovf[0], 0);
        snap = 1'b1;
        settle();
        read(0, 0, v);
        check("cleared_live_lo", v, 0);
        read(0, 1, v);
        check("cleared_live_hi", v, 0);

        // Randomized run against the reference model
        rst = 1'b1;
        clr = 1'b0; pause = 1'b0; edge_mode = M_BOTH; snap = 1'b0;
        sig_in = NUM_CH'($urandom);
        cyc(1);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk25);
            model_step(exp_dout);
            #1;
            check("rand_dout", dout, exp_dout);
            check("rand_ovf", ovf, m_ovf);
            sig_in   = NUM_CH'($urandom);
            pause    = ($urandom_range(0, 7) == 0);
            clr      = ($urandom_range(0, 63) == 0);
            snap     = 1'($urandom_range(0, 1));
            ch_sel   = CH_SEL_W'($urandom);
            byte_sel = BYTE_SEL_W'($urandom);
            if ($urandom_range(0, 15) == 0) edge_mode = 2'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
